// File: rtl/booth_mult_scheduler_if.sv
// Request/response bundle between the two requesters and the shared Booth multiplier.
// The master side drives operands and result-accepts; the slave side is the multiplier.
interface booth_mult_scheduler_if #(
  parameter int N = 32
);
  logic [1:0]     i_req_valid;
  logic [1:0]     o_req_ready;
  logic [N-1:0]   i_req0_a;
  logic [N-1:0]   i_req0_b;
  logic [N-1:0]   i_req1_a;
  logic [N-1:0]   i_req1_b;
  logic [1:0]     o_rsp_valid;
  logic [1:0]     i_rsp_ready;
  logic [2*N-1:0] o_result;
  logic           o_busy;

  modport master (
    output i_req_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_result, o_busy
  );

  modport slave (
    input  i_req_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_result, o_busy
  );
endinterface

// File: rtl/booth_mult_scheduler.sv
// Round-robin front end sharing one iterative radix-2 Booth multiplier between two
// requesters; one operation in flight, one Booth step per cycle.
module booth_mult_scheduler #(
  parameter int N = 32
) (
  input logic                    clk,
  input logic                    i_rst,
  booth_mult_scheduler_if.slave  bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic           rr_ptr;
  logic           grant_id;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   mplr;
  logic [N:0]     acc;
  logic           q0;
  logic [CW-1:0]  cnt;
  logic [1:0]     rsp_valid;
  logic [2*N-1:0] result;
  logic           busy;

  logic           any_valid;
  logic           grant;
  logic [1:0]     req_ready;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic [N:0]     a_ext;
  logic [N:0]     acc_sum;

  always_comb begin
    any_valid = |bus.i_req_valid;
    grant     = bus.i_req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    req_ready = 2'b00;
    if (state == IDLE && any_valid) begin
      req_ready[grant] = 1'b1;
    end
    sel_a = grant ? bus.i_req1_a : bus.i_req0_a;
    sel_b = grant ? bus.i_req1_b : bus.i_req0_b;
  end

  // Accumulator is one bit wider than the operands so subtracting -2^(N-1) cannot overflow.
  always_comb begin
    a_ext = {a_reg[N-1], a_reg};
    case ({mplr[0], q0})
      2'b01:   acc_sum = acc + a_ext;
      2'b10:   acc_sum = acc - a_ext;
      default: acc_sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      grant_id  <= 1'b0;
      a_reg     <= '0;
      mplr      <= '0;
      acc       <= '0;
      q0        <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 2'b00;
      result    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_reg    <= sel_a;
            mplr     <= sel_b;
            acc      <= '0;
            q0       <= 1'b0;
            cnt      <= '0;
            grant_id <= grant;
            rr_ptr   <= ~grant;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc  <= {acc_sum[N], acc_sum[N:1]};
          mplr <= {acc_sum[0], mplr[N-1:1]};
          q0   <= mplr[0];
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N-1)) begin
            state <= DONE;
          end
        end
        // First DONE cycle publishes the product; it then holds until the granted side accepts.
        DONE: begin
          if (rsp_valid == 2'b00) begin
            result    <= {acc[N-1:0], mplr};
            rsp_valid <= grant_id ? 2'b10 : 2'b01;
          end else if (bus.i_rsp_ready[grant_id]) begin
            result    <= '0;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_result    = result;
  assign bus.o_busy      = busy;

endmodule
